mem_bus_arbiter: RTL and testbench

- Shares the core's single data/instruction RAM port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Arbitrates round-robin between the two requesters.
- Registers the winner's request onto the memory port and returns read data with a one-cycle ack/err pulse.
- Guards against a hung slave with a timeout, and drives the LSU stall request to ctrl.

---
 rtl/mem_bus_arbiter_if.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - IFU/LSU/memory bus bundle for the memory port arbiter
// Purpose: groups the IFU and LSU request channels, the stall request and the
//          shared memory port into one bundle.
// Modports:
//   master - arbiter side: takes if_*_i / ls_*_i / mem_*_i, drives the *_o signals
//   slave  - environment side (IFU, LSU, ctrl, RAM): the mirror image
interface mem_bus_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        if_err_o;

  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_sel_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [31:0] ls_rdata_o;
  logic        ls_ack_o;
  logic        ls_err_o;

  logic        stall_req_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_sel_i, ls_addr_i, ls_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_rdata_o, if_ack_o, if_err_o,
    output ls_rdata_o, ls_ack_o, ls_err_o,
    output stall_req_o,
    output mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_sel_i, ls_addr_i, ls_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_rdata_o, if_ack_o, if_err_o,
    input  ls_rdata_o, ls_ack_o, ls_err_o,
    input  stall_req_o,
    input  mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin IFU/LSU arbiter for the single RAM port
// Purpose: shares one memory port between instruction fetch and load/store,
//          registers the winner's request, returns a one-cycle ack/err pulse and
//          aborts with an error if the slave does not ack within TIMEOUT_CYCLES.
// Ports:
//   clk_i   - core clock
//   n_rst_i - asynchronous active-low reset
//   bus     - mem_bus_arbiter_if.master (IFU, LSU, stall and memory signals)
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                clk_i,
  input  logic                n_rst_i,
  mem_bus_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Counter value at which a silent slave is given up on.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_sel_q, mem_sel_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      ls_rdata_q, ls_rdata_d;
  logic             grant_ls;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 4'b0000;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      if_rdata_q   <= 32'h0;
      ls_rdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  // LSU wins when it is alone, or on a tie when IFU had the last grant.
  // last_grant resets to IFU, so the first tie after reset goes to LSU.
  assign grant_ls = bus.ls_req_i & (~bus.if_req_i | (last_grant_q == OWN_IF));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.if_req_i || bus.ls_req_i) begin
          owner_d      = grant_ls ? OWN_LS : OWN_IF;
          last_grant_d = grant_ls ? OWN_LS : OWN_IF;
          err_d        = 1'b0;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          if (grant_ls) begin
            mem_we_d    = bus.ls_we_i;
            mem_sel_d   = bus.ls_sel_i;
            mem_addr_d  = bus.ls_addr_i;
            mem_wdata_d = bus.ls_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_sel_d   = 4'b1111;
            mem_addr_d  = bus.if_addr_i;
            mem_wdata_d = 32'h0;
          end
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        // Ack is tested first so it beats a timeout landing in the same cycle.
        if (bus.mem_ack_i) begin
          if (owner_q == OWN_LS) ls_rdata_d = bus.mem_rdata_i;
          else                   if_rdata_d = bus.mem_rdata_i;
          mem_req_d = 1'b0;
          state_d   = S_RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == TO_LAST) begin
            if (owner_q == OWN_LS) ls_rdata_d = 32'h0;
            else                   if_rdata_d = 32'h0;
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = S_RESP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Pulses are decoded from the RESP state so an asynchronous reset clears them at once.
  assign bus.if_ack_o    = (state_q == S_RESP) & (owner_q == OWN_IF) & ~err_q;
  assign bus.if_err_o    = (state_q == S_RESP) & (owner_q == OWN_IF) &  err_q;
  assign bus.ls_ack_o    = (state_q == S_RESP) & (owner_q == OWN_LS) & ~err_q;
  assign bus.ls_err_o    = (state_q == S_RESP) & (owner_q == OWN_LS) &  err_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.ls_rdata_o  = ls_rdata_q;
  assign bus.stall_req_o = bus.ls_req_i & ~bus.ls_ack_o & ~bus.ls_err_o;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_sel_o   = mem_sel_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  typedef struct {
    logic [3:0]  pulses;
    logic [31:0] rdata;
    bit          chk_rd;
  } resp_t;

  localparam logic [3:0] P_IF_ACK = 4'b1000;
  localparam logic [3:0] P_IF_ERR = 4'b0100;
  localparam logic [3:0] P_LS_ACK = 4'b0010;
  localparam logic [3:0] P_LS_ERR = 4'b0001;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clk_i  (clk),
    .n_rst_i(n_rst),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  grant_t exp_grants[$];
  resp_t  exp_resps[$];
  int     rises[$];
  int     rise_cyc = 0;
  int     hi_len = 0;
  int     resp_cyc = 0;
  int     resp_count = 0;

  int          slave_lat = 0;
  bit          slave_mute = 1'b0;
  logic [31:0] slave_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: acks after slave_lat cycles of mem_req_o, garbage rdata otherwise.
  initial begin : slave
    int  wcnt;
    bit  s_prev;
    wcnt   = 0;
    s_prev = 1'b0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'hDEADDEAD;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o) begin
        if (!s_prev) wcnt = 0;
        else         wcnt++;
      end
      s_prev = bus.mem_req_o;
      bus.mem_ack_i   = bus.mem_req_o && !slave_mute && (wcnt == slave_lat);
      bus.mem_rdata_i = bus.mem_ack_i ? slave_rdata : 32'hDEADDEAD;
    end
  end

  // Scoreboard monitor: grants checked on mem_req_o rise, responses on each pulse.
  initial begin : monitor
    bit          m_prev;
    grant_t      g;
    resp_t       r;
    logic [3:0]  pulses;
    m_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_o && !m_prev) begin
        rise_cyc = cyc;
        rises.push_back(cyc);
        if (exp_grants.size() == 0) begin
          chk("grant_unexpected", 32'(bus.mem_req_o), 32'h0);
        end else begin
          g = exp_grants.pop_front();
          chk("grant_addr", bus.mem_addr_o, g.addr);
          chk("grant_we", 32'(bus.mem_we_o), 32'(g.we));
          chk("grant_sel", 32'(bus.mem_sel_o), 32'(g.sel));
          chk("grant_wdata", bus.mem_wdata_o, g.wdata);
        end
      end
      if (!bus.mem_req_o && m_prev) hi_len = cyc - rise_cyc;
      m_prev = bus.mem_req_o;

      pulses = {bus.if_ack_o, bus.if_err_o, bus.ls_ack_o, bus.ls_err_o};
      if (pulses != 4'b0000) begin
        resp_cyc = cyc;
        resp_count++;
        if (exp_resps.size() == 0) begin
          chk("resp_unexpected", 32'(pulses), 32'h0);
        end else begin
          r = exp_resps.pop_front();
          chk("resp_kind", 32'(pulses), 32'(r.pulses));
          if (r.chk_rd)
            chk("resp_rdata", (r.pulses[3:2] != 2'b00) ? bus.if_rdata_o : bus.ls_rdata_o, r.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int target, input string tag);
    int n;
    n = 0;
    while (resp_count < target && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(resp_count >= target), 32'h1);
  endtask

  task automatic push_grant(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata);
    grant_t g;
    g.we = we; g.sel = sel; g.addr = addr; g.wdata = wdata;
    exp_grants.push_back(g);
  endtask

  task automatic push_resp(input logic [3:0] pulses, input logic [31:0] rdata, input bit chk_rd);
    resp_t r;
    r.pulses = pulses; r.rdata = rdata; r.chk_rd = chk_rd;
    exp_resps.push_back(r);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    n_rst          = 1'b0;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 32'h0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_sel_i   = 4'b0000;
    bus.ls_addr_i  = 32'h0;
    bus.ls_wdata_i = 32'h0;
    tick();
    tick();

    // Reset values
    chk("rst_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
    chk("rst_mem_sel", 32'(bus.mem_sel_o), 32'h0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
    chk("rst_ls_rdata", bus.ls_rdata_o, 32'h0);
    chk("rst_pulses", 32'({bus.if_ack_o, bus.if_err_o, bus.ls_ack_o, bus.ls_err_o}), 32'h0);
    chk("rst_stall", 32'(bus.stall_req_o), 32'h0);
    n_rst = 1'b1;
    tick();

    // Both requesters held from reset, zero-wait slave: LSU, IFU, LSU, IFU
    slave_lat   = 0;
    slave_rdata = 32'h1111_2222;
    rises.delete();
    push_grant(1'b0, 4'b1111, 32'h2004, 32'h55);
    push_grant(1'b0, 4'b1111, 32'h0000, 32'h0);
    push_grant(1'b0, 4'b1111, 32'h2004, 32'h55);
    push_grant(1'b0, 4'b1111, 32'h0000, 32'h0);
    push_resp(P_LS_ACK, 32'h1111_2222, 1'b1);
    push_resp(P_IF_ACK, 32'h1111_2222, 1'b1);
    push_resp(P_LS_ACK, 32'h1111_2222, 1'b1);
    push_resp(P_IF_ACK, 32'h1111_2222, 1'b1);
    base = resp_count;
    bus.if_addr_i  = 32'h0000;
    bus.ls_we_i    = 1'b0;
    bus.ls_sel_i   = 4'b1111;
    bus.ls_addr_i  = 32'h2004;
    bus.ls_wdata_i = 32'h55;
    bus.if_req_i   = 1'b1;
    bus.ls_req_i   = 1'b1;
    wait_resp(base + 4, "alt");
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    tick();
    tick();
    chk("alt_grants", 32'(rises.size()), 32'd4);
    for (int i = 0; i + 1 < rises.size(); i++)
      chk("alt_spacing", 32'(rises[i+1] - rises[i]), 32'd3);

    // Single IFU read, slave acks 2 cycles after mem_req_o
    slave_lat   = 2;
    slave_rdata = 32'h0000_0013;
    push_grant(1'b0, 4'b1111, 32'h100, 32'h0);
    push_resp(P_IF_ACK, 32'h13, 1'b1);
    base = resp_count;
    bus.if_addr_i = 32'h100;
    bus.if_req_i  = 1'b1;
    chk("ifu_req_before", 32'(bus.mem_req_o), 32'h0);
    tick();
    chk("ifu_req_t1", 32'(bus.mem_req_o), 32'h1);
    wait_resp(base + 1, "ifu");
    bus.if_req_i = 1'b0;
    chk("ifu_ack_latency", 32'(resp_cyc - rise_cyc), 32'd3);
    tick();

    // LSU store with stall tracking
    slave_lat   = 1;
    slave_rdata = 32'h77;
    push_grant(1'b1, 4'b0011, 32'h2000, 32'hBEEF);
    push_resp(P_LS_ACK, 32'h0, 1'b0);
    bus.ls_we_i    = 1'b1;
    bus.ls_sel_i   = 4'b0011;
    bus.ls_addr_i  = 32'h2000;
    bus.ls_wdata_i = 32'hBEEF;
    bus.ls_req_i   = 1'b1;
    #1;
    chk("st_stall_start", 32'(bus.stall_req_o), 32'h1);
    begin : st_loop
      for (int n = 0; n < 60; n++) begin
        tick();
        if (bus.ls_ack_o || bus.ls_err_o) begin
          chk("st_stall_at_ack", 32'(bus.stall_req_o), 32'h0);
          disable st_loop;
        end
        chk("st_stall_wait", 32'(bus.stall_req_o), 32'h1);
      end
      chk("st_ack_seen", 32'h0, 32'h1);
    end
    bus.ls_req_i = 1'b0;
    bus.ls_we_i  = 1'b0;
    tick();
    tick();

    // Timeout on an LSU load, slave never acks
    slave_mute = 1'b1;
    push_grant(1'b0, 4'b1111, 32'h3000, 32'h0);
    push_resp(P_LS_ERR, 32'h0, 1'b1);
    base = resp_count;
    bus.ls_sel_i   = 4'b1111;
    bus.ls_addr_i  = 32'h3000;
    bus.ls_wdata_i = 32'h0;
    bus.ls_req_i   = 1'b1;
    wait_resp(base + 1, "tmo");
    bus.ls_req_i = 1'b0;
    chk("tmo_req_len", 32'(hi_len), 32'd4);
    chk("tmo_ls_rdata", bus.ls_rdata_o, 32'h0);
    tick();

    // IFU served normally after the timeout
    slave_mute  = 1'b0;
    slave_lat   = 1;
    slave_rdata = 32'hA5A5_A5A5;
    push_grant(1'b0, 4'b1111, 32'h104, 32'h0);
    push_resp(P_IF_ACK, 32'hA5A5_A5A5, 1'b1);
    base = resp_count;
    bus.if_addr_i = 32'h104;
    bus.if_req_i  = 1'b1;
    wait_resp(base + 1, "post_tmo");
    bus.if_req_i = 1'b0;
    tick();

    // Ack arriving in the cycle the timeout would fire
    slave_lat   = 3;
    slave_rdata = 32'hCAFE_F00D;
    push_grant(1'b0, 4'b1111, 32'h400, 32'h0);
    push_resp(P_IF_ACK, 32'hCAFE_F00D, 1'b1);
    base = resp_count;
    bus.if_addr_i = 32'h400;
    bus.if_req_i  = 1'b1;
    wait_resp(base + 1, "ack_vs_tmo");
    bus.if_req_i = 1'b0;
    chk("ack_vs_tmo_len", 32'(hi_len), 32'd4);
    chk("ack_vs_tmo_rdata", bus.if_rdata_o, 32'hCAFE_F00D);
    tick();

    // Asynchronous reset while BUSY
    slave_mute = 1'b1;
    push_grant(1'b0, 4'b1111, 32'h500, 32'h0);
    bus.if_addr_i = 32'h500;
    bus.if_req_i  = 1'b1;
    tick();
    tick();
    chk("abort_busy", 32'(bus.mem_req_o), 32'h1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("abort_pulses", 32'({bus.if_ack_o, bus.if_err_o, bus.ls_ack_o, bus.ls_err_o}), 32'h0);
    chk("abort_if_rdata", bus.if_rdata_o, 32'h0);
    tick();
    slave_mute  = 1'b0;
    slave_lat   = 0;
    slave_rdata = 32'h600D;
    push_grant(1'b0, 4'b1111, 32'h600, 32'h0);
    push_resp(P_LS_ACK, 32'h600D, 1'b1);
    base = resp_count;
    bus.ls_we_i   = 1'b0;
    bus.ls_sel_i  = 4'b1111;
    bus.ls_addr_i = 32'h600;
    bus.ls_req_i  = 1'b1;
    tick();
    n_rst = 1'b1;
    wait_resp(base + 1, "post_rst");
    bus.if_req_i = 1'b0;
    bus.ls_req_i = 1'b0;
    tick();
    tick();
    tick();

    chk("grants_left", 32'(exp_grants.size()), 32'h0);
    chk("resps_left", 32'(exp_resps.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
